// File: rtl/alu_seq.sv
// Sequential ALU: ADD/SUB/AND/XOR/OR/SLT single-cycle, MUL by shift-add.
// Define ALU_FLAGS_EN to add registered zero/negative/carry outputs.
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             negative,
  output logic             carry,
`endif
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Single-cycle datapath works straight off the input operands
  logic [WIDTH-1:0] b_opnd;
  logic             cin;
  logic [WIDTH:0]   sum_w;
  logic             msb_cin;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  always_comb begin
    cin     = (select == OP_SUB);
    b_opnd  = cin ? ~b : b;
    sum_w   = {1'b0, a} + {1'b0, b_opnd}
            + {{WIDTH{1'b0}}, cin};
    msb_cin = a[WIDTH-1] ^ b_opnd[WIDTH-1]
            ^ sum_w[WIDTH-1];
    add_ovf = sum_w[WIDTH] ^ msb_cin;
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (select)
      OP_ADD, OP_SUB: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_ovf = add_ovf;
      end
      OP_AND: alu_res = a & b;
      OP_XOR: alu_res = a ^ b;
      OP_OR:  alu_res = a | b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                         $signed(a) < $signed(b)};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // One multiplier bit per step: add multiplicand into the high half,
  // then shift the whole accumulator right, consuming b from the bottom.
  logic [WIDTH:0]     part_w;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    part_w   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {part_w, acc_q[WIDTH-1:1]};
  end

  logic             res_load;
  logic [WIDTH-1:0] res_val;
  logic             res_ovf;
`ifdef ALU_FLAGS_EN
  logic             res_carry;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_load = 1'b0;
    res_val  = '0;
    res_ovf  = 1'b0;
`ifdef ALU_FLAGS_EN
    res_carry = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          if (select == OP_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            res_load = 1'b1;
            res_val  = alu_res;
            res_ovf  = alu_ovf;
`ifdef ALU_FLAGS_EN
            res_carry = (select == OP_ADD ||
                         select == OP_SUB) &&
                        sum_w[WIDTH];
`endif
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_load = 1'b1;
          res_val  = acc_step[WIDTH-1:0];
          res_ovf  = |acc_step[2*WIDTH-1:WIDTH];
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_d   = res_load ? res_val : s_q;
    ovf_d = res_load ? res_ovf : ovf_q;
`ifdef ALU_FLAGS_EN
    zero_d  = res_load ? (res_val == '0) : zero_q;
    neg_d   = res_load ? res_val[WIDTH-1] : neg_q;
    carry_d = res_load ? res_carry : carry_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef ALU_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef ALU_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign overflow  = ovf_q;
`ifdef ALU_FLAGS_EN
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = carry_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq against an arithmetic reference.
// Flag outputs are checked when ALU_FLAGS_EN is defined.
module tb_alu_seq;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   select;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         carry;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
`ifdef ALU_FLAGS_EN
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
`endif
    .overflow  (overflow)
  );

`ifndef ALU_FLAGS_EN
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign carry    = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_op(
    input  logic [2:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] rs,
    output logic         ro,
    output logic         rc
  );
    logic signed [W:0]  se;
    logic [W:0]         u;
    logic [2*W-1:0]     p;
    rs = '0;
    ro = 1'b0;
    rc = 1'b0;
    case (op)
      3'd0: begin
        rs = x + y;
        se = $signed({x[W-1], x}) + $signed({y[W-1], y});
        ro = se[W] != se[W-1];
        u  = {1'b0, x} + {1'b0, y};
        rc = u[W];
      end
      3'd1: begin
        rs = x - y;
        se = $signed({x[W-1], x}) - $signed({y[W-1], y});
        ro = se[W] != se[W-1];
        rc = (x >= y);
      end
      3'd2: rs = x & y;
      3'd3: rs = x ^ y;
      3'd4: rs = x | y;
      3'd5: rs = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      3'd6: begin
        p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        rs = p[W-1:0];
        ro = |p[2*W-1:W];
      end
      default: rs = '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      4: v = W'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Drives one op with out_ready=1, reports result and accept-to-valid latency
  task automatic do_op(
    input  logic [2:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] rs,
    output logic         ro,
    output logic         rz,
    output logic         rn,
    output logic         rc,
    output int           lat
  );
    int wait_n;
    @(negedge clk);
    wait_n = 0;
    while (!in_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    n_checks++;
    if (wait_n >= 200) begin
      n_fail++;
      $display("FAIL in_ready_wait: in_ready=%b after %0d cycles",
               in_ready, wait_n);
    end
    select    = op;
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    rs = s;
    ro = overflow;
    rz = zero;
    rn = negative;
    rc = carry;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    select    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, overflow} !== 3'b100 || s !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b ovf=%b s=%h want 1 0 0 0",
               in_ready, out_valid, overflow, s);
    end
`ifdef ALU_FLAGS_EN
    n_checks++;
    if ({zero, negative, carry} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: z/n/c=%b%b%b want 000",
               zero, negative, carry);
    end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] rs;
    logic         ro, rz, rn, rc;
    int           lat;

    do_op(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, rs, ro, rz, rn, rc, lat);
    n_checks++;
    if (rs !== 64'h8000_0000_0000_0000 || ro !== 1'b1 || lat != 1) begin
      n_fail++;
      $display("FAIL add_ovf: s=%h ovf=%b lat=%0d want 8000000000000000 1 1",
               rs, ro, lat);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retire_idle: vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end

    do_op(3'd1, 64'd5, 64'd7, rs, ro, rz, rn, rc, lat);
    n_checks++;
    if (rs !== 64'hFFFF_FFFF_FFFF_FFFE || ro !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_neg: s=%h ovf=%b want fffffffffffffffe 0", rs, ro);
    end

    do_op(3'd5, '1, 64'd1, rs, ro, rz, rn, rc, lat);
    n_checks++;
    if (rs !== 64'd1 || ro !== 1'b0) begin
      n_fail++;
      $display("FAIL slt_true: s=%h ovf=%b want 1 0", rs, ro);
    end

    do_op(3'd5, 64'd1, '1, rs, ro, rz, rn, rc, lat);
    n_checks++;
    if (rs !== 64'd0) begin
      n_fail++;
      $display("FAIL slt_false: s=%h want 0", rs);
    end

    do_op(3'd6, 64'd3, 64'd5, rs, ro, rz, rn, rc, lat);
    n_checks++;
    if (rs !== 64'd15 || ro !== 1'b0 || lat != 65) begin
      n_fail++;
      $display("FAIL mul_small: s=%h ovf=%b lat=%0d want 15 0 65",
               rs, ro, lat);
    end

    do_op(3'd6, 64'h1_0000_0000, 64'h1_0000_0000,
          rs, ro, rz, rn, rc, lat);
    n_checks++;
    if (rs !== 64'd0 || ro !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_ovf: s=%h ovf=%b want 0 1", rs, ro);
    end

    do_op(3'd7, 64'd9, 64'd3, rs, ro, rz, rn, rc, lat);
    n_checks++;
    if (rs !== 64'd0 || ro !== 1'b0 || lat != 1) begin
      n_fail++;
      $display("FAIL reserved_op: s=%h ovf=%b lat=%0d want 0 0 1",
               rs, ro, lat);
    end
`ifdef ALU_FLAGS_EN
    n_checks++;
    if (rz !== 1'b1 || rc !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_flags: z=%b c=%b want 1 0", rz, rc);
    end
    do_op(3'd1, 64'd9, 64'd9, rs, ro, rz, rn, rc, lat);
    n_checks++;
    if ({rz, rc, rn} !== 3'b110) begin
      n_fail++;
      $display("FAIL sub_eq_flags: z/c/n=%b%b%b want 110", rz, rc, rn);
    end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, rs, es;
    logic [2:0]   op;
    logic         ro, rz, rn, rc, eo, ec;
    int           lat, elat;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = rnd_opnd();
      y  = rnd_opnd();
      ref_op(op, x, y, es, eo, ec);
      elat = (op == 3'd6) ? W + 1 : 1;
      do_op(op, x, y, rs, ro, rz, rn, rc, lat);
      n_checks++;
      if (rs !== es || ro !== eo || lat != elat) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: s=%h ovf=%b lat=%0d want %h %b %0d",
                 i, op, x, y, rs, ro, lat, es, eo, elat);
      end
`ifdef ALU_FLAGS_EN
      n_checks++;
      if (rz !== (es == '0) || rn !== es[W-1] || rc !== ec) begin
        n_fail++;
        $display("FAIL random_flags[%0d]: z/n/c=%b%b%b want %b%b%b",
                 i, rz, rn, rc, (es == '0), es[W-1], ec);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int bad;
    @(negedge clk);
    select    = 3'd0;
    a         = 64'h7FFF_FFFF_FFFF_FFFF;
    b         = 64'h10;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    select = 3'd3;
    a      = 64'hF0;
    b      = 64'h0F;
    bad    = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          s !== 64'h8000_0000_0000_000F || overflow !== 1'b1)
        bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles want 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retire_no_accept: vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || s !== 64'hFF || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL held_op_result: vld=%b s=%h ovf=%b want 1 ff 0",
               out_valid, s, overflow);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    @(negedge clk);
    select    = 3'd6;
    a         = 64'h1234_5678;
    b         = 64'h9ABC_DEF0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || s !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: vld=%b s=%h ovf=%b want 0 0 0",
               out_valid, s, overflow);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: rdy=%b want 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL no_result_after_reset: %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [7];
    logic [W-1:0] xs  [7];
    logic [W-1:0] ys  [7];
    logic [W-1:0] es;
    logic         eo, ec;
    for (int i = 0; i < 7; i++) begin
      ops[i] = 3'($urandom_range(0, 6));
      if (ops[i] == 3'd6) ops[i] = 3'd7;
      xs[i] = rnd_opnd();
      ys[i] = rnd_opnd();
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    select    = ops[0];
    a         = xs[0];
    b         = ys[0];
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      ref_op(ops[k], xs[k], ys[k], es, eo, ec);
      n_checks++;
      if (out_valid !== 1'b1 || s !== es || overflow !== eo) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: vld=%b s=%h ovf=%b want 1 %h %b",
                 k, out_valid, s, overflow, es, eo);
      end
      select = ops[k+1];
      a      = xs[k+1];
      b      = ys[k+1];
      if (k == 5) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: vld=%b rdy=%b want 0 1",
                 k, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
